rd_buffer_drain_ctrl: RTL and testbench
=======================================

Name: rd_buffer_drain_ctrl

Overview:
- Pointer, occupancy and handshake controller that surrounds the team's dual-port read-return buffer.
- Accepts PHY-side write beats on a valid/ready interface and drives the buffer write port (we, writePtr).
- Drains entries in order to the cache-side consumer on a valid/ready interface. It drives the buffer read port (re, readPtr) and absorbs the buffer's 1-cycle registered read latency in a 2-entry output skid.
- Guarantees the buffer never sees a same-address read/write in one cycle, and tags burst boundaries with a last flag.

Parameters:
- BufferDepth, 8, number of buffer entries; power of two, >= 2.
- BurstLen, 4, beats per burst; power of two, >= 1; drives out_last.
- DataEntry, logic [63:0], beat payload type; matches the buffer's DataEntry.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  PHY beat valid.
- in_ready  output  1  space available: occupancy < BufferDepth.
- buf_we  output  1  buffer write enable.
- buf_writePtr  output  $clog2(BufferDepth)  buffer write address.
- buf_re  output  1  buffer read enable.
- buf_readPtr  output  $clog2(BufferDepth)  buffer read address.
- buf_rdata  input  DataEntry  buffer registered read data.
- out_valid  output  1  consumer beat valid (skid non-empty).
- out_ready  input  1  consumer accepts beat.
- out_data  output  DataEntry  skid head data.
- out_last  output  1  final beat of a BurstLen burst.
- occupancy  output  $clog2(BufferDepth)+1  entries written but not yet issued for read.

Behaviour:
- Pointers
  - wptr and rptr are $clog2(BufferDepth)+1 bits; the extra MSB is the wrap bit.
  - occupancy = wptr - rptr, modulo 2^(width).
  - Full when occupancy == BufferDepth; empty when occupancy == 0.
- Write side
  - in_ready = !full, from registered pointers only.
  - Accept = in_valid && in_ready. Then buf_we = 1 and buf_writePtr = wptr[low bits] combinationally; wptr increments at the edge.
  - buf_we = 0 otherwise; buf_writePtr = wptr[low bits] always.
- Read issue
  - pop = out_valid && out_ready.
  - issue = !empty && (skid_cnt + inflight_q - pop < 2).
  - On issue: buf_re = 1, buf_readPtr = rptr[low bits], rptr increments, inflight_q <= 1. Otherwise inflight_q <= 0.
- RAW safety
  - A beat written in cycle N is not counted in occupancy until N+1, so it is never read in the cycle it is written.
  - When full, no write occurs, so readPtr == writePtr never coincides with re && we.
- Skid
  - 2-entry FIFO.
  - When inflight_q = 1, buf_rdata is pushed at the edge.
  - out_data = head; out_valid = skid_cnt != 0.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible by construction; an assertion checks it.
- Latency
  - Write accepted at edge N: out_valid rises in cycle N+3 when the skid is empty and out_ready is held.
  - Sustained throughput is 1 beat/cycle in both directions.
- Bursts
  - beat_cnt ($clog2(BurstLen) bits, min 1) increments on pop and wraps after BurstLen-1.
  - out_last = (beat_cnt == BurstLen-1). When BurstLen = 1, out_last is always 1.
- Simultaneous write + issue
  - Both pointers advance and occupancy is unchanged.
  - Occupancy 0 with a write this cycle: no issue this cycle.
- Reset (any time, including mid-burst)
  - Next edge clears wptr, rptr, inflight_q, skid_cnt, skid pointers and beat_cnt.
  - Reset values: in_ready = 1, buf_we = 0, buf_re = 0, out_valid = 0, out_last = (BurstLen == 1), occupancy = 0, pointers = 0, out_data = 0.
  - Beats in flight are discarded.
- Assertions
  - No re && we with equal addresses.
  - skid_cnt <= 2.
  - occupancy <= BufferDepth.
  - out_data held stable while out_valid && !out_ready.

Decomposition:
- Shared package holds:
  - the default beat typedef (64-bit read-return entry);
  - a ptr-width helper constant function.
- One natural sub-module: rd_drain_skid, the 2-entry FIFO with push, pop, head and count.
- The pointer/issue logic stays in the top module.
- The bench instantiates the existing dual-port buffer alongside the controller.

Test Plan:
- Single beat, Depth 8: write 0xA5 at edge 0, out_ready = 1 -> buf_re in cycle 1; out_valid, out_data = 0xA5 and out_last = 0 in cycle 3; occupancy returns to 0.
- Fill: 8 back-to-back writes with out_ready = 0 -> skid holds 2 beats, occupancy = 6, in_ready = 1. Two more writes -> occupancy = 8, in_ready = 0, and a further in_valid is not written.
- Streaming: 16 beats (values 0..15) with in_valid = 1 and out_ready = 1 -> one beat per cycle out, in order; out_last on beats 3, 7, 11, 15; no re/we address collision.
- Backpressure: random out_ready (50%) over 64 beats -> no loss or duplication; out_data stable while stalled; skid_cnt never exceeds 2.
- Wrap-around: 3 passes of 8 beats -> pointer MSB toggles; occupancy correct across the wrap; data order preserved.
- Reset mid-burst: assert rst after beat 2 of 4 with occupancy 3 -> next cycle out_valid = 0, occupancy = 0, in_ready = 1; the next burst starts with beat_cnt = 0.

Source files
------------

// File: rtl/rd_buffer_drain_ctrl_pkg.sv
// Shared types and helpers for the read-return buffer drain controller.
// Holds the default beat payload and the pointer-width rule used by the pointer logic.
package rd_buffer_drain_ctrl_pkg;

  typedef logic [63:0] data_entry_t;

  // Pointer width carries one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rd_drain_skid.sv
// Two-entry output skid FIFO that absorbs the buffer's registered read latency.
// Push and pop in the same cycle are both honoured; the head is presented combinationally.
module rd_drain_skid
  import rd_buffer_drain_ctrl_pkg::*;
#(
  parameter type DataEntry = data_entry_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  DataEntry push_data,
  input  logic     pop,
  output DataEntry head,
  output logic [1:0] count
);

  DataEntry mem [2];
  logic     wr_sel;
  logic     rd_sel;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this tiny storage is reset on purpose so out_data reads zero out of reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_sel] <= push_data;
        wr_sel      <= ~wr_sel;
      end
      if (pop) begin
        rd_sel <= ~rd_sel;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_sel];

endmodule

// File: rtl/rd_buffer_drain_ctrl.sv
// Pointer, occupancy and valid/ready controller around the dual-port read-return buffer.
// Writes PHY beats into the buffer and drains them in order through a 2-entry skid.
module rd_buffer_drain_ctrl
  import rd_buffer_drain_ctrl_pkg::*;
#(
  parameter int  BufferDepth = 8,
  parameter int  BurstLen    = 4,
  parameter type DataEntry   = data_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         buf_we,
  output logic [$clog2(BufferDepth)-1:0] buf_writePtr,
  output logic                         buf_re,
  output logic [$clog2(BufferDepth)-1:0] buf_readPtr,
  input  DataEntry                     buf_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output DataEntry                     out_data,
  output logic                         out_last,
  output logic [$clog2(BufferDepth):0] occupancy
);

  localparam int AddrW = $clog2(BufferDepth);
  localparam int PtrW  = ptr_width(BufferDepth);
  localparam int BeatW = (BurstLen > 1) ? $clog2(BurstLen) : 1;

  localparam logic [PtrW-1:0]  DepthCount = PtrW'(BufferDepth);
  localparam logic [BeatW-1:0] LastBeat   = BeatW'(BurstLen - 1);

  logic [PtrW-1:0]  wptr;
  logic [PtrW-1:0]  rptr;
  logic             inflight_q;
  logic [1:0]       skid_cnt;
  logic [BeatW-1:0] beat_cnt;
  logic [2:0]       pending;
  logic             full;
  logic             empty;
  logic             accept;
  logic             pop;
  logic             issue;

  // A beat written this cycle only shows up in occupancy next cycle, so it is never read early.
  assign occupancy = wptr - rptr;
  assign full      = (occupancy == DepthCount);
  assign empty     = (occupancy == '0);

  assign in_ready     = ~full;
  assign accept       = in_valid & in_ready;
  assign buf_we       = accept;
  assign buf_writePtr = wptr[AddrW-1:0];

  // Issue only while the skid plus the read already in flight leaves room after this pop.
  assign pop     = out_valid & out_ready;
  assign pending = {1'b0, skid_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = ~empty & (pending < 3'd2);

  assign buf_re      = issue;
  assign buf_readPtr = rptr[AddrW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      inflight_q <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      if (accept) begin
        wptr <= wptr + 1'b1;
      end
      if (issue) begin
        rptr <= rptr + 1'b1;
      end
      inflight_q <= issue;
      if (pop) begin
        beat_cnt <= (beat_cnt == LastBeat) ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  rd_drain_skid #(
    .DataEntry (DataEntry)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (buf_rdata),
    .pop       (pop),
    .head      (out_data),
    .count     (skid_cnt)
  );

  assign out_valid = (skid_cnt != 2'd0);
  assign out_last  = (beat_cnt == LastBeat);

  a_no_raw_collision: assert property (@(posedge clk) disable iff (rst)
    !(buf_re && buf_we && (buf_readPtr == buf_writePtr)));
  a_skid_bound: assert property (@(posedge clk) disable iff (rst) skid_cnt <= 2'd2);
  a_skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (inflight_q && !pop) |-> (skid_cnt != 2'd2));
  a_occupancy_bound: assert property (@(posedge clk) disable iff (rst) occupancy <= DepthCount);
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_rd_buffer_drain_ctrl.sv
// Directed bench for rd_buffer_drain_ctrl with a behavioural model of the dual-port buffer.
// A negedge monitor scores drained beats against the accepted-write order.
module tb_rd_buffer_drain_ctrl;
  import rd_buffer_drain_ctrl_pkg::*;

  localparam int Depth = 8;
  localparam int Burst = 4;
  localparam int AddrW = $clog2(Depth);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             buf_we;
  logic [AddrW-1:0] buf_writePtr;
  logic             buf_re;
  logic [AddrW-1:0] buf_readPtr;
  data_entry_t      buf_rdata;
  logic             out_valid;
  logic             out_ready;
  data_entry_t      out_data;
  logic             out_last;
  logic [AddrW:0]   occupancy;
  data_entry_t      in_data;

  data_entry_t buf_mem [Depth];

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          exp_beat = 0;
  data_entry_t exp_q [$];
  logic        stall_prev = 1'b0;
  data_entry_t stall_data = '0;

  rd_buffer_drain_ctrl #(
    .BufferDepth (Depth),
    .BurstLen    (Burst)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .buf_we       (buf_we),
    .buf_writePtr (buf_writePtr),
    .buf_re       (buf_re),
    .buf_readPtr  (buf_readPtr),
    .buf_rdata    (buf_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .occupancy    (occupancy)
  );

  // Dual-port buffer: write port takes PHY data, read port is registered.
  always @(posedge clk) begin
    if (buf_we) buf_mem[buf_writePtr] <= in_data;
    if (buf_re) buf_rdata <= buf_mem[buf_readPtr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: accepted writes queue up, pops must come out in order with the burst tag.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      exp_beat   = 0;
      stall_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (buf_re && buf_we) check("raw_addr_differ", 64'(buf_readPtr != buf_writePtr), 64'd1);
      if (stall_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_pop", 64'(exp_q.size()), 64'd1);
        end else begin
          check("pop_data", out_data, exp_q.pop_front());
          check("pop_last", 64'(out_last), 64'(exp_beat == Burst - 1));
          exp_beat = (exp_beat + 1) % Burst;
          pops++;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic run_backpressure();
    logic writer_done;
    writer_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          logic accepted;
          accepted = 1'b0;
          in_valid = 1'b1;
          in_data  = 64'hB000 + 64'(i);
          for (int g = 0; g < 200 && !accepted; g++) begin
            @(negedge clk);
            accepted = in_ready;
            tick();
          end
          if (!accepted) check("bp_write_timeout", 64'(accepted), 64'd1);
        end
        in_valid    = 1'b0;
        writer_done = 1'b1;
      end
      begin
        for (int n = 0; n < 3000 && !(writer_done && exp_q.size() == 0); n++) begin
          out_ready = writer_done ? 1'b1 : ($urandom_range(0, 1) == 1);
          tick();
        end
        out_ready = 1'b1;
      end
    join
  endtask

  initial begin
    int start;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;

    // Reset values
    tick();
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_buf_we", 64'(buf_we), 64'd0);
    check("rst_buf_re", 64'(buf_re), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_wptr", 64'(buf_writePtr), 64'd0);
    check("rst_rptr", 64'(buf_readPtr), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    tick();
    rst = 1'b0;

    // Single beat: write at cycle 0, read issue in 1, visible in 3
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hA5;
    @(negedge clk);
    check("single_we", 64'(buf_we), 64'd1);
    check("single_wptr", 64'(buf_writePtr), 64'd0);
    check("single_no_early_re", 64'(buf_re), 64'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("single_re", 64'(buf_re), 64'd1);
    check("single_rptr", 64'(buf_readPtr), 64'd0);
    check("single_occ1", 64'(occupancy), 64'd1);
    check("single_c1_valid", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("single_c2_valid", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("single_c3_valid", 64'(out_valid), 64'd1);
    check("single_c3_data", out_data, 64'hA5);
    check("single_c3_last", 64'(out_last), 64'd0);
    tick();
    @(negedge clk);
    check("single_c4_valid", 64'(out_valid), 64'd0);
    check("single_c4_occ", 64'(occupancy), 64'd0);
    tick();

    // Fill with consumer stalled
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h10 + 64'(i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("fill_occ6", 64'(occupancy), 64'd6);
    check("fill_ready6", 64'(in_ready), 64'd1);
    check("fill_head", out_data, 64'h10);
    check("fill_valid", 64'(out_valid), 64'd1);
    tick();
    in_valid = 1'b1;
    in_data  = 64'h18;
    tick();
    in_data = 64'h19;
    tick();
    in_data = 64'hEE;
    @(negedge clk);
    check("full_occ8", 64'(occupancy), 64'd8);
    check("full_not_ready", 64'(in_ready), 64'd0);
    check("full_no_we", 64'(buf_we), 64'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("full_occ_hold", 64'(occupancy), 64'd8);
    check("full_queued", 64'(exp_q.size()), 64'd10);
    tick();
    drain("fill_drain");

    // Streaming at one beat per cycle
    do_reset();
    out_ready = 1'b1;
    start = pops;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("stream_pops", 64'(pops - start), 64'd16);
    check("stream_empty", 64'(exp_q.size()), 64'd0);

    // Random consumer backpressure
    do_reset();
    start = pops;
    run_backpressure();
    check("bp_pops", 64'(pops - start), 64'd64);
    check("bp_empty", 64'(exp_q.size()), 64'd0);

    // Wrap-around: three fill/drain passes of eight beats
    do_reset();
    for (int p = 0; p < 3; p++) begin
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
        in_valid = 1'b1;
        in_data  = 64'hC0 + 64'(8 * p + i);
        tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("wrap_occ6", 64'(occupancy), 64'd6);
      check("wrap_rptr", 64'(buf_readPtr), 64'd2);
      tick();
      drain("wrap_drain");
      @(negedge clk);
      check("wrap_occ0", 64'(occupancy), 64'd0);
      tick();
    end

    // Reset in the middle of a burst
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h30 + 64'(i);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 5; i < 7; i++) begin
      in_data = 64'h30 + 64'(i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("mid_occ3", 64'(occupancy), 64'd3);
    check("mid_head", out_data, 64'h32);
    check("mid_last", 64'(out_last), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_last", 64'(out_last), 64'd0);
    tick();
    out_ready = 1'b1;
    start = pops;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h40 + 64'(i);
      tick();
    end
    drain("post_rst_drain");
    check("post_rst_pops", 64'(pops - start), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
